cal_e1_frac: RTL and testbench



---
 rtl/cal_e1_frac.sv | 139 +++++++++++++
 tb/tb_cal_e1_frac.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cal_e1_frac.sv
// cal_e1_frac: sequential restoring divider producing e1 = err_cnt / tot_cnt
// as an unsigned fixed-point fraction with E1_AMP fractional bits. One quotient
// bit is resolved per clock; the result is presented with a one-cycle valid
// pulse, or flagged as an error when the ratio is undefined or exceeds 1.
module cal_e1_frac #(
    parameter int E1_AMP = 24,
    parameter int ROUND  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [31:0] i_err_cnt,
    input  logic [31:0] i_tot_cnt,
    output logic [31:0] o_e1,
    output logic        o_e1_vld,
    output logic        o_e1_busy,
    output logic        o_e1_error
);

    // Full quotient word width and number of shift-subtract iterations.
    // ROUND=1 resolves one extra bit that is used only for rounding.
    localparam int QW = E1_AMP + 1;
    localparam int N  = E1_AMP + ROUND;

    typedef enum logic [1:0] {IDLE, CHECK, DIV, DONE} state_t;

    state_t              state;
    logic [5:0]          cnt;
    logic [31:0]         err_r;
    logic [31:0]         tot_r;
    logic [32:0]         r;
    logic [E1_AMP-1:0]   q;
    logic                q_int;

    logic [33:0]         r2;
    logic [32:0]         diff;
    logic                ge;
    logic [32:0]         r_nxt;
    logic [QW-1:0]       q_nxt;
    logic                bad;

    // Combine the integer bit with the fraction bits. In rounding mode the
    // extra LSB is added back in after the shift, i.e. (x + 1) >> 1.
    function automatic logic [31:0] form_result(input logic qi, input logic [QW-1:0] qv);
        logic [31:0] res;
        if (ROUND == 0)
            res = 32'({qi, qv[E1_AMP-1:0]});
        else
            res = 32'({qi, qv[E1_AMP:1]}) + 32'(qv[0]);
        return res;
    endfunction

    // One restoring step: doubled remainder compared against the divisor.
    // The shift register holds the bits resolved so far; appending this
    // cycle's bit gives the complete E1_AMP+1 bit quotient word.
    always_comb begin
        r2    = {r, 1'b0};
        ge    = (r2 >= {2'b00, tot_r});
        diff  = r2[32:0] - {1'b0, tot_r};
        r_nxt = ge ? diff : r2[32:0];
        q_nxt = {q, ge};
        bad   = (tot_r == 32'd0) || (err_r > tot_r);
    end

    // Control FSM and registered outputs; reset returns everything to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            o_e1       <= '0;
            o_e1_vld   <= 1'b0;
            o_e1_busy  <= 1'b0;
            o_e1_error <= 1'b0;
        end else begin
            o_e1_vld <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        o_e1_busy  <= 1'b1;
                        o_e1_error <= 1'b0;
                        state      <= CHECK;
                    end
                end
                CHECK: begin
                    cnt <= 6'(N);
                    if (bad) begin
                        o_e1_error <= 1'b1;
                        o_e1       <= '0;
                        o_e1_vld   <= 1'b1;
                        state      <= DONE;
                    end else begin
                        state <= DIV;
                    end
                end
                DIV: begin
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd1) begin
                        o_e1     <= form_result(q_int, q_nxt);
                        o_e1_vld <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    o_e1_busy <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand latch and divider datapath; only the FSM state gates updates.
    always_ff @(posedge clk) begin
        unique case (state)
            IDLE: begin
                if (i_start) begin
                    err_r <= i_err_cnt;
                    tot_r <= i_tot_cnt;
                end
            end
            CHECK: begin
                q <= '0;
                if (err_r == tot_r) begin
                    q_int <= 1'b1;
                    r     <= '0;
                end else begin
                    q_int <= 1'b0;
                    r     <= {1'b0, err_r};
                end
            end
            DIV: begin
                r <= r_nxt;
                q <= q_nxt[E1_AMP-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cal_e1_frac.sv
// Testbench for cal_e1_frac: a truncating and a rounding instance share the
// same stimulus; expected results come from a plain-arithmetic model and are
// queued per instance, then checked by independent monitors on each vld.
module tb_cal_e1_frac;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [31:0] i_err_cnt;
    logic [31:0] i_tot_cnt;

    logic [31:0] e1_0, e1_1;
    logic        vld_0, vld_1, busy_0, busy_1, err_0, err_1;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] e1;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic [31:0] last_e1_0, last_e1_1;
    logic        last_err;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cal_e1_frac #(.E1_AMP(24), .ROUND(0)) u0 (
        .clk(clk), .rst(rst), .i_start(i_start),
        .i_err_cnt(i_err_cnt), .i_tot_cnt(i_tot_cnt),
        .o_e1(e1_0), .o_e1_vld(vld_0), .o_e1_busy(busy_0), .o_e1_error(err_0)
    );

    cal_e1_frac #(.E1_AMP(24), .ROUND(1)) u1 (
        .clk(clk), .rst(rst), .i_start(i_start),
        .i_err_cnt(i_err_cnt), .i_tot_cnt(i_tot_cnt),
        .o_e1(e1_1), .o_e1_vld(vld_1), .o_e1_busy(busy_1), .o_e1_error(err_1)
    );

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: e1 = err * 2^24 / tot. Rounding mode takes the 25-bit
    // quotient and rounds its extra LSB away: (q + 1) / 2.
    function automatic logic [31:0] model_e1(input logic [31:0] e, input logic [31:0] t, input int rnd);
        longint unsigned num, quo;
        num = {32'd0, e};
        if (rnd == 0) begin
            quo = (num << 24) / t;
        end else begin
            quo = (num << 25) / t;
            quo = (quo + 1) / 2;
        end
        return quo[31:0];
    endfunction

    always @(negedge clk) begin
        if (vld_0) begin
            if (q0.size() == 0) begin
                check("u0 unexpected vld", 1, 0);
            end else begin
                exp_t x;
                x = q0.pop_front();
                check("u0 e1", e1_0, x.e1);
                check("u0 error", err_0, x.err);
                check("u0 vld cycle", cyc, x.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (vld_1) begin
            if (q1.size() == 0) begin
                check("u1 unexpected vld", 1, 0);
            end else begin
                exp_t x;
                x = q1.pop_front();
                check("u1 e1", e1_1, x.e1);
                check("u1 error", err_1, x.err);
                check("u1 vld cycle", cyc, x.cyc);
            end
        end
    end

    // One transaction. poke>0 pulses i_start at T+poke while busy;
    // rst_at>0 asserts rst at T+rst_at and expects the computation aborted.
    task automatic run_txn(input logic [31:0] e, input logic [31:0] t, input int poke, input int rst_at);
        int   T, lat0, lat1, end_c;
        logic bad;
        exp_t x;
        @(posedge clk);
        #1;
        i_err_cnt = e;
        i_tot_cnt = t;
        i_start   = 1'b1;
        T         = cyc;
        bad       = (t == 32'd0) || (e > t);
        lat0      = bad ? 2 : 26;
        lat1      = bad ? 2 : 27;
        if (rst_at < 0) begin
            x.err = bad;
            x.e1  = bad ? 32'd0 : model_e1(e, t, 0);
            x.cyc = T + lat0;
            q0.push_back(x);
            last_e1_0 = x.e1;
            x.e1  = bad ? 32'd0 : model_e1(e, t, 1);
            x.cyc = T + lat1;
            q1.push_back(x);
            last_e1_1 = x.e1;
            last_err  = bad;
            end_c     = T + lat1 + 1;
        end else begin
            last_e1_0 = 32'd0;
            last_e1_1 = 32'd0;
            last_err  = 1'b0;
            end_c     = T + rst_at + 2;
        end
        @(posedge clk);
        #1;
        i_start   = 1'b0;
        i_err_cnt = $urandom;
        i_tot_cnt = $urandom;
        while (cyc < end_c) begin
            @(negedge clk);
            if (rst_at < 0) begin
                check("u0 busy", busy_0, cyc <= T + lat0);
                check("u1 busy", busy_1, cyc <= T + lat1);
            end else begin
                check("u0 busy", busy_0, cyc <= T + rst_at);
                check("u1 busy", busy_1, cyc <= T + rst_at);
            end
            if (cyc == T + 1) begin
                check("u0 error cleared", err_0, 0);
                check("u1 error cleared", err_1, 0);
            end
            if (poke > 0 && cyc == T + poke) begin
                i_start   = 1'b1;
                i_err_cnt = $urandom;
                i_tot_cnt = $urandom;
            end else if (poke > 0 && cyc == T + poke + 1) begin
                i_start = 1'b0;
            end
            if (rst_at > 0 && cyc == T + rst_at) rst = 1'b1;
            else if (rst_at > 0 && cyc == T + rst_at + 1) rst = 1'b0;
        end
        check("u0 e1 hold", e1_0, last_e1_0);
        check("u1 e1 hold", e1_1, last_e1_1);
        check("u0 error hold", err_0, last_err);
        check("u1 error hold", err_1, last_err);
        check("u0 vld idle", vld_0, 0);
        check("u1 vld idle", vld_1, 0);
    endtask

    initial begin
        logic [31:0] re, rt;
        longint unsigned tl;
        int mode;
        rst       = 1'b1;
        i_start   = 1'b0;
        i_err_cnt = '0;
        i_tot_cnt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset e1 u0", e1_0, 0);
        check("reset e1 u1", e1_1, 0);
        check("reset vld u0", vld_0, 0);
        check("reset vld u1", vld_1, 0);
        check("reset busy u0", busy_0, 0);
        check("reset busy u1", busy_1, 0);
        check("reset error u0", err_0, 0);
        check("reset error u1", err_1, 0);
        rst = 1'b0;

        run_txn(32'd1, 32'd4, -1, -1);
        run_txn(32'd1, 32'd3, -1, -1);
        run_txn(32'd2, 32'd3, -1, -1);
        run_txn(32'd1000, 32'd1000, -1, -1);
        run_txn(32'd0, 32'd7, -1, -1);
        run_txn(32'd0, 32'd0, -1, -1);
        run_txn(32'd3, 32'd9, -1, -1);
        run_txn(32'd5, 32'd4, -1, -1);
        run_txn(32'hFFFF_FFFE, 32'hFFFF_FFFF, -1, -1);
        run_txn(32'd7, 32'd11, 5, -1);
        run_txn(32'd1, 32'd4, -1, 10);
        run_txn(32'd2, 32'd3, -1, -1);

        // Reset and start together: the start must be dropped.
        @(negedge clk);
        rst       = 1'b1;
        i_start   = 1'b1;
        i_err_cnt = 32'd1;
        i_tot_cnt = 32'd2;
        @(negedge clk);
        rst     = 1'b0;
        i_start = 1'b0;
        check("rst+start busy u0", busy_0, 0);
        check("rst+start busy u1", busy_1, 0);
        check("rst+start e1 u0", e1_0, 0);
        check("rst+start error u0", err_0, 0);
        last_e1_0 = 32'd0;
        last_e1_1 = 32'd0;

        for (int i = 0; i < 24; i++) begin
            mode = int'($urandom_range(0, 6));
            case (mode)
                0: begin rt = 32'd0; re = $urandom; end
                1: begin rt = $urandom_range(1, 100000); re = rt + $urandom_range(1, 1000); end
                2: begin rt = $urandom; re = rt; end
                3: begin rt = $urandom_range(1, 50); re = $urandom_range(0, 50); end
                default: begin
                    rt = $urandom | 32'd1;
                    tl = longint'(rt) + 1;
                    re = 32'(longint'($urandom) % tl);
                end
            endcase
            run_txn(re, rt, (i % 5 == 3) ? int'($urandom_range(3, 20)) : -1, -1);
        end

        repeat (4) @(negedge clk);
        check("u0 pending expectations", q0.size(), 0);
        check("u1 pending expectations", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
